// File: rtl/idli_sqr_m.sv
// Nibble-serial instruction sequencer: owns the nibble counter, the INIT/FETCH/EXEC
// state machine, the serial PC increment and the register selector hold for EXEC.
module idli_sqr_m #(
   parameter logic [15:0] PC_RST = 16'h0000
) (
   input  logic       i_sqr_gck,
   input  logic       i_sqr_rst,
   input  logic [3:0] i_sqr_mem_data,
   input  logic       i_sqr_mem_vld,
   input  logic       i_sqr_a_wen,
   input  logic [3:0] i_sqr_pc_data,
   output logic       o_sqr_mem_req,
   output logic [1:0] o_sqr_ctr,
   output logic       o_sqr_exec,
   output logic [6:0] o_sqr_op,
   output logic [2:0] o_sqr_grf_a,
   output logic       o_sqr_grf_a_vld,
   output logic [2:0] o_sqr_grf_b,
   output logic [2:0] o_sqr_grf_c,
   output logic       o_sqr_grf_pc_vld,
   output logic [3:0] o_sqr_grf_pc_data
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_ctr;
   logic [15:0] r_instr;
   logic        r_carry;
   logic        r_act;
   logic        w_act;
   logic        w_cin;
   logic [4:0]  w_sum;
   logic        w_fetch_act;

   // The memory valid is only looked at on nibble 0; the rest of the slot follows r_act.
   assign w_act       = (r_ctr == 2'd0) ? i_sqr_mem_vld : r_act;
   assign w_cin       = (r_ctr == 2'd0) ? 1'b1 : r_carry;
   assign w_sum       = {1'b0, i_sqr_pc_data} + {4'd0, w_cin};
   assign w_fetch_act = (r_state == ST_FETCH) && w_act;

   assign o_sqr_ctr   = r_ctr;
   assign o_sqr_op    = r_instr[15:9];
   assign o_sqr_grf_c = r_instr[8:6];
   assign o_sqr_grf_b = r_instr[5:3];
   assign o_sqr_grf_a = r_instr[2:0];

   // State register and free-running nibble counter.
   always_ff @(posedge i_sqr_gck) begin
      if (i_sqr_rst) begin
         r_state <= ST_INIT;
         r_ctr   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_ctr   <= r_ctr + 2'd1;
      end
   end

   // Fetch datapath: instruction shift-in, PC carry chain and slot activity.
   always_ff @(posedge i_sqr_gck) begin
      if (i_sqr_rst) begin
         r_instr <= 16'h0000;
         r_carry <= 1'b0;
         r_act   <= 1'b0;
      end else begin
         if (r_state == ST_FETCH) begin
            r_act <= w_act;
         end else begin
            r_act <= 1'b0;
         end
         if (w_fetch_act) begin
            r_instr <= {i_sqr_mem_data, r_instr[15:4]};
            r_carry <= w_sum[4];
         end else begin
            r_instr <= r_instr;
            r_carry <= r_carry;
         end
      end
   end

   // Next-state logic; transitions only on the last nibble of a slot.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: begin
            if (r_ctr == 2'd3) w_state_nxt = ST_FETCH;
            else               w_state_nxt = ST_INIT;
         end
         ST_FETCH: begin
            if ((r_ctr == 2'd3) && w_act) w_state_nxt = ST_EXEC;
            else                          w_state_nxt = ST_FETCH;
         end
         ST_EXEC: begin
            if (r_ctr == 2'd3) w_state_nxt = ST_FETCH;
            else               w_state_nxt = ST_EXEC;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // Output decode; A and PC write enables are mutually exclusive by state.
   always_comb begin
      o_sqr_mem_req     = 1'b0;
      o_sqr_exec        = 1'b0;
      o_sqr_grf_a_vld   = 1'b0;
      o_sqr_grf_pc_vld  = 1'b0;
      o_sqr_grf_pc_data = 4'd0;
      case (r_state)
         ST_INIT: begin
            o_sqr_grf_pc_vld  = 1'b1;
            o_sqr_grf_pc_data = PC_RST[{r_ctr, 2'b00} +: 4];
         end
         ST_FETCH: begin
            o_sqr_mem_req = 1'b1;
            if (w_act) begin
               o_sqr_grf_pc_vld  = 1'b1;
               o_sqr_grf_pc_data = w_sum[3:0];
            end else begin
               o_sqr_grf_pc_vld  = 1'b0;
               o_sqr_grf_pc_data = 4'd0;
            end
         end
         ST_EXEC: begin
            o_sqr_exec      = 1'b1;
            o_sqr_grf_a_vld = i_sqr_a_wen;
         end
         default: begin
            o_sqr_mem_req     = 1'b0;
            o_sqr_exec        = 1'b0;
            o_sqr_grf_a_vld   = 1'b0;
            o_sqr_grf_pc_vld  = 1'b0;
            o_sqr_grf_pc_data = 4'd0;
         end
      endcase
   end

endmodule
